// File: rtl/x_imem_rv32i.sv
// Word memory behind the rv32i core's memory port: fixed-latency reads through an
// in-order response buffer, plus a one-cycle program-load write port.
module x_imem_rv32i #(
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2,
  parameter int OUTSTAND = 1
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        o_req_accept,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  input  logic        i_rsp_accept,
  input  logic        i_ld_valid,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_accept
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(OUTSTAND + 1);
  localparam int PW = (OUTSTAND > 1) ? $clog2(OUTSTAND) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic          v;
    logic          err;
    logic [AW-1:0] idx;
  } stage_t;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTAND - 1)) ? '0 : p + PW'(1);
  endfunction

  logic          req_err, ld_err, ld_we, rsp_hs, push;
  logic [AW-1:0] req_idx, ld_idx;
  logic [CW-1:0] inflight_q, inflight_d;
  stage_t        req_s, rd_s;
  logic [31:0]   rd_data;

  assign req_err = addr_err(i_req_addr);
  assign ld_err  = addr_err(i_ld_addr);
  assign req_idx = i_req_addr[AW+1:2];
  assign ld_idx  = i_ld_addr[AW+1:2];

  // Loads win over reads; the in-flight cap keeps the response buffer from overflowing.
  assign o_req_accept = i_req_valid & ~i_ld_valid & (inflight_q < CW'(OUTSTAND));
  assign o_ld_accept  = i_ld_valid;
  assign ld_we        = i_ld_valid & ~ld_err;

  // ---------------------------------------------------------------- storage
  logic [31:0]      mem_q [DEPTH];
  logic [DEPTH-1:0] written_q;

  // NOTE: the RAM array has no reset; the per-word written bits carry the reset meaning.
  always_ff @(posedge i_clk) begin
    if (ld_we) mem_q[ld_idx] <= i_ld_data;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)    written_q         <= '0;
    else if (ld_we) written_q[ld_idx] <= 1'b1;
  end

  // ---------------------------------------------------------------- read pipeline
  assign req_s = '{v: o_req_accept, err: req_err, idx: req_idx};

  generate
    if (LATENCY == 1) begin : g_lat1
      assign rd_s = req_s;
    end else begin : g_latn
      stage_t pipe_q [LATENCY-1];

      always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
          for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= req_s;
          for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign rd_s = pipe_q[LATENCY-2];
    end
  endgenerate

  // Write-first: a load hitting the word being read this cycle returns the new data.
  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    if (!rd_s.err) begin
      if (ld_we && (ld_idx == rd_s.idx)) rd_data = i_ld_data;
      else if (written_q[rd_s.idx])      rd_data = mem_q[rd_s.idx];
      else                               rd_data = NOP;
    end
  end

  assign push = rd_s.v;

  // ---------------------------------------------------------------- response buffer
  logic [31:0]         fifo_data_q [OUTSTAND];
  logic [OUTSTAND-1:0] fifo_err_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;

  assign o_rsp_valid = (count_q != '0);
  assign rsp_hs      = o_rsp_valid & i_rsp_accept;
  assign o_rsp_data  = o_rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign o_rsp_err   = o_rsp_valid & fifo_err_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rd_data;
      fifo_err_q[wr_ptr_q]  <= rd_s.err;
    end
  end

  always_comb begin
    count_d    = count_q;
    inflight_d = inflight_q;
    if (push && !rsp_hs)              count_d    = count_q + CW'(1);
    else if (rsp_hs && !push)         count_d    = count_q - CW'(1);
    if (o_req_accept && !rsp_hs)      inflight_d = inflight_q + CW'(1);
    else if (rsp_hs && !o_req_accept) inflight_d = inflight_q - CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (push)   wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rsp_hs) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_x_imem_rv32i.sv
// Bench for x_imem_rv32i: two instances (OUTSTAND=1 and 3, LATENCY=2) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_x_imem_rv32i;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  int outs [2] = '{1, 3};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid  [2];
  logic [31:0] req_addr   [2];
  logic        req_accept [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_data   [2];
  logic        rsp_err    [2];
  logic        rsp_accept [2];
  logic        ld_valid   [2];
  logic [31:0] ld_addr    [2];
  logic [31:0] ld_data    [2];
  logic        ld_accept  [2];

  always #5 clk = ~clk;

  x_imem_rv32i #(.DEPTH(DEPTH), .LATENCY(LAT), .OUTSTAND(1)) u_dut_o1 (
    .i_clk(clk), .i_nrst(rst_n),
    .i_req_valid(req_valid[0]), .i_req_addr(req_addr[0]), .o_req_accept(req_accept[0]),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_data(rsp_data[0]), .o_rsp_err(rsp_err[0]),
    .i_rsp_accept(rsp_accept[0]),
    .i_ld_valid(ld_valid[0]), .i_ld_addr(ld_addr[0]), .i_ld_data(ld_data[0]),
    .o_ld_accept(ld_accept[0])
  );

  x_imem_rv32i #(.DEPTH(DEPTH), .LATENCY(LAT), .OUTSTAND(3)) u_dut_o3 (
    .i_clk(clk), .i_nrst(rst_n),
    .i_req_valid(req_valid[1]), .i_req_addr(req_addr[1]), .o_req_accept(req_accept[1]),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_data(rsp_data[1]), .o_rsp_err(rsp_err[1]),
    .i_rsp_accept(rsp_accept[1]),
    .i_ld_valid(ld_valid[1]), .i_ld_addr(ld_addr[1]), .i_ld_data(ld_data[1]),
    .o_ld_accept(ld_accept[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- model
  // Each accepted request becomes a ticket: visible at accept+LAT, its data resolved from
  // the model memory at accept+LAT-1 (after that cycle's load), retired on handshake.
  typedef struct {
    int          ready;
    int          rd;
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
  } pend_t;

  pend_t       pq   [2][$];
  logic [31:0] mmem [2][DEPTH];
  bit          mwr  [2][DEPTH];
  int          cyc = 0;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      bit    exp_acc, head_vis;
      pend_t e;
      if (!rst_n) begin
        check($sformatf("reset rsp_valid[%0d]", k), rsp_valid[k], 0);
        check($sformatf("reset rsp_data[%0d]", k), rsp_data[k], 0);
        check($sformatf("reset rsp_err[%0d]", k), rsp_err[k], 0);
        pq[k].delete();
        for (int i = 0; i < DEPTH; i++) mwr[k][i] = 1'b0;
      end else begin
        exp_acc  = req_valid[k] && !ld_valid[k] && (pq[k].size() < outs[k]);
        head_vis = (pq[k].size() > 0) && (pq[k][0].ready <= cyc);
        check($sformatf("req_accept[%0d]", k), req_accept[k], exp_acc);
        check($sformatf("ld_accept[%0d]", k), ld_accept[k], ld_valid[k]);
        check($sformatf("rsp_valid[%0d]", k), rsp_valid[k], head_vis);
        if (head_vis) begin
          check($sformatf("rsp_data[%0d]", k), rsp_data[k], pq[k][0].data);
          check($sformatf("rsp_err[%0d]", k), rsp_err[k], pq[k][0].err);
        end else begin
          check($sformatf("idle rsp_data[%0d]", k), rsp_data[k], 0);
        end
        if (ld_valid[k] && !bad_addr(ld_addr[k])) begin
          mmem[k][ld_addr[k] / 4] = ld_data[k];
          mwr[k][ld_addr[k] / 4]  = 1'b1;
        end
        if (exp_acc) begin
          e.ready = cyc + LAT;
          e.rd    = cyc + LAT - 1;
          e.err   = bad_addr(req_addr[k]);
          e.addr  = req_addr[k];
          e.data  = 32'h0;
          pq[k].push_back(e);
        end
        for (int j = 0; j < pq[k].size(); j++) begin
          if (pq[k][j].rd == cyc) begin
            e = pq[k][j];
            if (e.err)                  e.data = 32'h0;
            else if (mwr[k][e.addr / 4]) e.data = mmem[k][e.addr / 4];
            else                        e.data = NOP;
            pq[k][j] = e;
          end
        end
        if (head_vis && rsp_accept[k]) void'(pq[k].pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
    ld_valid[k] = 1'b1;
    ld_addr[k]  = a;
    ld_data[k]  = d;
    tick();
    ld_valid[k] = 1'b0;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic read_wait(input int k, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_e, input string name);
    bit got  = 1'b0;
    bit seen = 1'b0;
    int n    = 0;
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_accept[k];
    end
    check({name, " accepted"}, got, 1);
    tick();
    req_valid[k] = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      seen = rsp_valid[k];
    end
    check({name, " latency"}, n, LAT);
    check({name, " data"}, rsp_data[k], exp_d);
    check({name, " err"}, rsp_err[k], exp_e);
    tick();
  endtask

  logic [31:0] words [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};

  initial begin
    int          nacc, last, nr;
    bit          have;
    logic [31:0] held;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; rsp_accept[k] = 1'b1;
      ld_valid[k]  = 1'b0; ld_addr[k]  = '0; ld_data[k]    = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Program image and first reads
    for (int i = 0; i < 4; i++) load(0, 32'(i * 4), words[i]);
    for (int i = 0; i < 4; i++) load(1, 32'(i * 4), words[i]);
    read_wait(0, 32'h0, 32'h0010_0093, 1'b0, "read 0x0");
    read_wait(0, 32'h4, 32'h0020_0113, 1'b0, "read 0x4");

    // Unwritten word, misaligned, out of range
    read_wait(0, 32'h40,  NOP,   1'b0, "read unwritten");
    read_wait(0, 32'h2,   32'h0, 1'b1, "read misaligned");
    read_wait(0, 32'h400, 32'h0, 1'b1, "read out of range");

    // Held request with a single slot: one accept every LAT+1 cycles
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h8;
    nacc = 0;
    last = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (req_accept[0]) begin
        if (nacc > 0) check("hold spacing", i - last, LAT + 1);
        last = i;
        nacc++;
      end
      if (rsp_valid[0]) check("hold rsp data", rsp_data[0], 32'h0030_0193);
    end
    check("hold accept count", nacc, 5);
    tick();
    req_valid[0] = 1'b0;
    repeat (4) tick();

    // Three slots, consumer stalled, then released
    rsp_accept[1] = 1'b0;
    req_valid[1]  = 1'b1;
    nacc = 0;
    have = 1'b0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      req_addr[1] = 32'(4 * (i % 4));
      @(negedge clk);
      check("stall accept window", req_accept[1], i < 3);
      if (req_accept[1]) nacc++;
      if (rsp_valid[1]) begin
        if (!have) begin
          held = rsp_data[1];
          have = 1'b1;
          check("stall head data", held, 32'h0010_0093);
        end else begin
          check("stall data stable", rsp_data[1], held);
        end
      end
      tick();
    end
    check("stall accept count", nacc, 3);
    rsp_accept[1] = 1'b1;
    nacc = 0;
    nr   = 0;
    for (int i = 0; i < 10; i++) begin
      req_addr[1] = 32'(4 * (i % 4));
      @(negedge clk);
      if (rsp_valid[1]) begin
        if (nr < 3) check("release order", rsp_data[1], words[nr]);
        nr++;
      end
      if (req_accept[1]) nacc++;
      tick();
    end
    check("release rsp count", nr >= 3, 1);
    check("accepts resume", nacc > 0, 1);
    req_valid[1] = 1'b0;
    repeat (5) tick();

    // Load into the word at its read stage: new data comes back
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h14;
    @(negedge clk);
    check("wf accept", req_accept[1], 1);
    tick();
    req_valid[1] = 1'b0;
    ld_valid[1]  = 1'b1;
    ld_addr[1]   = 32'h14;
    ld_data[1]   = 32'h0AAA_0AAA;
    tick();
    ld_valid[1] = 1'b0;
    @(negedge clk);
    check("wf rsp_valid", rsp_valid[1], 1);
    check("wf rsp_data", rsp_data[1], 32'h0AAA_0AAA);
    tick();

    // Load and request together: load wins, read next cycle sees it
    ld_valid[0]  = 1'b1;
    ld_addr[0]   = 32'hC;
    ld_data[0]   = 32'h0050_0293;
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'hC;
    @(negedge clk);
    check("collide ld_accept", ld_accept[0], 1);
    check("collide req_accept", req_accept[0], 0);
    tick();
    ld_valid[0] = 1'b0;
    read_wait(0, 32'hC, 32'h0050_0293, 1'b0, "read after load");

    // Reset while a response is held in the buffer
    rsp_accept[0] = 1'b0;
    req_valid[0]  = 1'b1;
    req_addr[0]   = 32'h0;
    @(negedge clk);
    check("pre-reset accept", req_accept[0], 1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    check("pre-reset rsp_valid", rsp_valid[0], 1);
    rst_n = 1'b0;
    #1;
    check("async reset rsp_valid", rsp_valid[0], 0);
    tick();
    tick();
    rst_n         = 1'b1;
    rsp_accept[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no stale rsp", rsp_valid[0], 0);
    end
    tick();
    read_wait(0, 32'h0, NOP, 1'b0, "post-reset unwritten");

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
